// File: rtl/race_pkg.sv
// Shared key codes, game-state and winner encodings for the drag-racing game.
// Used by the sequencer, the keyboard decode and the overlay drawers.
package race_pkg;

  localparam logic [3:0] KEY_NONE  = 4'd0;
  localparam logic [3:0] KEY_ENTER = 4'd1;
  localparam logic [3:0] KEY_P1    = 4'd2;
  localparam logic [3:0] KEY_P2    = 4'd3;
  localparam logic [3:0] KEY_ESC   = 4'd4;

  typedef enum logic [1:0] {
    GS_MENU      = 2'd0,
    GS_COUNTDOWN = 2'd1,
    GS_RACE      = 2'd2,
    GS_FINISH    = 2'd3
  } game_state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

endpackage

// File: rtl/race_if.sv
// Key/frame inputs and race status outputs of the game sequencer.
// The sequencer is the slave side; the keyboard/VGA environment is the master side.
interface race_if;
  logic [3:0]  key_code;
  logic        vblnk_in;
  logic [1:0]  game_state;
  logic [1:0]  lights;
  logic [10:0] xpos_p1;
  logic [10:0] xpos_p2;
  logic [1:0]  winner;
  logic [1:0]  false_start;

  modport master (
    output key_code, vblnk_in,
    input  game_state, lights, xpos_p1, xpos_p2, winner, false_start
  );

  modport slave (
    input  key_code, vblnk_in,
    output game_state, lights, xpos_p1, xpos_p2, winner, false_start
  );
endinterface

// File: rtl/car_physics.sv
// Speed and position of one car: throttle acceleration, periodic decay, and
// per-frame position advance clamped at the finish line.
module car_physics #(
  parameter int unsigned START_X   = 256,
  parameter int unsigned FINISH_X  = 960,
  parameter int unsigned ACCEL     = 4,
  parameter int unsigned MAX_SPEED = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        throttle,
  input  logic        tick,
  input  logic        clear,
  input  logic        decay_en,
  output logic [10:0] xpos,
  output logic        at_finish
);

  logic [5:0]  speed_q, speed_d;
  logic [10:0] xpos_q, xpos_d;
  logic [11:0] xsum;
  logic [10:0] xnext;
  logic [7:0]  ssum;

  always_comb begin
    // Position advances with the speed held before this cycle's throttle/decay.
    xsum  = {1'b0, xpos_q} + {6'd0, speed_q};
    xnext = (xsum >= 12'(FINISH_X)) ? 11'(FINISH_X) : xsum[10:0];

    ssum = {2'b00, speed_q} + (throttle ? 8'(ACCEL) : 8'd0);
    if (tick && decay_en && (ssum != 8'd0)) begin
      ssum = ssum - 8'd1;
    end
    if (ssum > 8'(MAX_SPEED)) begin
      ssum = 8'(MAX_SPEED);
    end

    speed_d = speed_q;
    xpos_d  = xpos_q;
    if (clear) begin
      speed_d = 6'd0;
      xpos_d  = 11'(START_X);
    end else begin
      speed_d = ssum[5:0];
      if (tick) begin
        xpos_d = xnext;
      end
    end

    // Flags the tick that lands on the line, so the winner registers with the position.
    at_finish = tick && !clear && (xnext == 11'(FINISH_X));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed_q <= 6'd0;
      xpos_q  <= 11'(START_X);
    end else begin
      speed_q <= speed_d;
      xpos_q  <= xpos_d;
    end
  end

  assign xpos = xpos_q;

endmodule

// File: rtl/race_ctrl.sv
// Drag-racing game sequencer: MENU -> COUNTDOWN -> RACE -> FINISH, driven by
// one-cycle key codes and frame ticks derived from the vertical blank.
module race_ctrl
  import race_pkg::*;
#(
  parameter int unsigned START_X       = 256,
  parameter int unsigned FINISH_X      = 960,
  parameter int unsigned ACCEL         = 4,
  parameter int unsigned MAX_SPEED     = 48,
  parameter int unsigned DECAY_FRAMES  = 4,
  parameter int unsigned COUNT_FRAMES  = 60,
  parameter int unsigned RESULT_FRAMES = 300
) (
  input  logic   clk,
  input  logic   rst,
  race_if.slave  bus
);

  game_state_e state_q, state_d;
  logic [1:0]  lights_q, lights_d;
  logic [8:0]  frame_q, frame_d;
  logic [7:0]  decay_q, decay_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  fs_q, fs_d;
  logic [1:0]  fs_set;
  logic        vblnk_q, tick_q;
  logic        clear, tick_race, decay_en, thr1, thr2, fin1, fin2;
  logic [10:0] xpos1, xpos2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vblnk_q <= bus.vblnk_in;
      tick_q  <= bus.vblnk_in & ~vblnk_q;
    end
  end

  assign tick_race = tick_q && (state_q == GS_RACE);
  assign decay_en  = (decay_q == 8'(DECAY_FRAMES - 1));
  assign thr1      = (state_q == GS_RACE) && (bus.key_code == KEY_P1);
  assign thr2      = (state_q == GS_RACE) && (bus.key_code == KEY_P2);

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    frame_d  = frame_q;
    decay_d  = decay_q;
    winner_d = winner_q;
    fs_d     = fs_q;
    fs_set   = 2'b00;
    clear    = 1'b0;

    if (bus.key_code == KEY_ESC) begin
      state_d = GS_MENU;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        GS_MENU: begin
          if (bus.key_code == KEY_ENTER) begin
            state_d  = GS_COUNTDOWN;
            lights_d = 2'd3;
            clear    = 1'b1;
          end
        end
        GS_COUNTDOWN: begin
          if (bus.key_code == KEY_P1 || bus.key_code == KEY_P2) begin
            fs_set   = fs_q | ((bus.key_code == KEY_P1) ? 2'b01 : 2'b10);
            fs_d     = fs_set;
            winner_d = (fs_set == 2'b11) ? WIN_TIE : (fs_set[0] ? WIN_P2 : WIN_P1);
            state_d  = GS_FINISH;
            lights_d = 2'd0;
            frame_d  = 9'd0;
          end else if (tick_q) begin
            if (frame_q == 9'(COUNT_FRAMES - 1)) begin
              frame_d  = 9'd0;
              lights_d = lights_q - 2'd1;
              if (lights_q == 2'd1) begin
                state_d = GS_RACE;
              end
            end else begin
              frame_d = frame_q + 9'd1;
            end
          end
        end
        GS_RACE: begin
          if (tick_q) begin
            decay_d = decay_en ? 8'd0 : decay_q + 8'd1;
            if (fin1 || fin2) begin
              winner_d = (fin1 && fin2) ? WIN_TIE : (fin1 ? WIN_P1 : WIN_P2);
              state_d  = GS_FINISH;
              frame_d  = 9'd0;
            end
          end
        end
        GS_FINISH: begin
          if (bus.key_code == KEY_ENTER) begin
            state_d = GS_MENU;
            clear   = 1'b1;
          end else if (tick_q) begin
            if (frame_q == 9'(RESULT_FRAMES - 1)) begin
              state_d = GS_MENU;
              clear   = 1'b1;
            end else begin
              frame_d = frame_q + 9'd1;
            end
          end
        end
      endcase
    end

    // Clearing always leaves everything but the state and lights at reset values.
    if (clear) begin
      if (state_d == GS_MENU) begin
        lights_d = 2'd0;
      end
      frame_d  = 9'd0;
      decay_d  = 8'd0;
      winner_d = WIN_NONE;
      fs_d     = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= GS_MENU;
      lights_q <= 2'd0;
      frame_q  <= 9'd0;
      decay_q  <= 8'd0;
      winner_q <= WIN_NONE;
      fs_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      frame_q  <= frame_d;
      decay_q  <= decay_d;
      winner_q <= winner_d;
      fs_q     <= fs_d;
    end
  end

  car_physics #(
    .START_X  (START_X),
    .FINISH_X (FINISH_X),
    .ACCEL    (ACCEL),
    .MAX_SPEED(MAX_SPEED)
  ) u_car_p1 (
    .clk      (clk),
    .rst      (rst),
    .throttle (thr1),
    .tick     (tick_race),
    .clear    (clear),
    .decay_en (decay_en),
    .xpos     (xpos1),
    .at_finish(fin1)
  );

  car_physics #(
    .START_X  (START_X),
    .FINISH_X (FINISH_X),
    .ACCEL    (ACCEL),
    .MAX_SPEED(MAX_SPEED)
  ) u_car_p2 (
    .clk      (clk),
    .rst      (rst),
    .throttle (thr2),
    .tick     (tick_race),
    .clear    (clear),
    .decay_en (decay_en),
    .xpos     (xpos2),
    .at_finish(fin2)
  );

  assign bus.game_state  = state_q;
  assign bus.lights      = lights_q;
  assign bus.xpos_p1     = xpos1;
  assign bus.xpos_p2     = xpos2;
  assign bus.winner      = winner_q;
  assign bus.false_start = fs_q;

endmodule

// File: tb/tb_race_ctrl.sv
// Scoreboard bench for race_ctrl: a behavioural game model predicts every output
// after each key press or frame, and the DUT is compared against it.
module tb_race_ctrl;
  import race_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  race_if bus ();

  race_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    gs;
    int    lights;
    int    x1;
    int    x2;
    int    win;
    int    fs;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural game model
  int m_gs, m_lights, m_frame, m_dc, m_sp1, m_sp2, m_x1, m_x2, m_win, m_fs;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_lights = 0; m_frame = 0; m_dc = 0; m_sp1 = 0; m_sp2 = 0;
    m_x1 = 256; m_x2 = 256; m_win = 0; m_fs = 0;
  endfunction

  function automatic int clamp_speed(input int v);
    if (v < 0) return 0;
    if (v > 48) return 48;
    return v;
  endfunction

  function automatic void model_step(input int key, input bit tick);
    int  s1, s2;
    bit  dec, f1, f2;
    if (key == int'(KEY_ESC)) begin
      m_gs = 0;
      model_clear();
      return;
    end
    case (m_gs)
      0: if (key == int'(KEY_ENTER)) begin
        model_clear();
        m_gs = 1;
        m_lights = 3;
      end
      1: begin
        if (key == int'(KEY_P1) || key == int'(KEY_P2)) begin
          m_fs = m_fs | ((key == int'(KEY_P1)) ? 1 : 2);
          m_win = (m_fs == 3) ? 3 : ((m_fs == 1) ? 2 : 1);
          m_gs = 3; m_lights = 0; m_frame = 0;
        end else if (tick) begin
          if (m_frame == 59) begin
            m_frame = 0;
            m_lights--;
            if (m_lights == 0) m_gs = 2;
          end else m_frame++;
        end
      end
      2: begin
        dec = 0;
        if (tick) begin
          m_x1 = (m_x1 + m_sp1 > 960) ? 960 : m_x1 + m_sp1;
          m_x2 = (m_x2 + m_sp2 > 960) ? 960 : m_x2 + m_sp2;
          m_dc++;
          if (m_dc == 4) begin dec = 1; m_dc = 0; end
        end
        s1 = m_sp1 + ((key == int'(KEY_P1)) ? 4 : 0);
        s2 = m_sp2 + ((key == int'(KEY_P2)) ? 4 : 0);
        m_sp1 = clamp_speed(s1 - int'(dec));
        m_sp2 = clamp_speed(s2 - int'(dec));
        f1 = tick && (m_x1 == 960);
        f2 = tick && (m_x2 == 960);
        if (f1 || f2) begin
          m_win = (f1 && f2) ? 3 : (f1 ? 1 : 2);
          m_gs = 3; m_frame = 0;
        end
      end
      default: begin
        if (key == int'(KEY_ENTER)) begin
          m_gs = 0; model_clear();
        end else if (tick) begin
          if (m_frame == 299) begin m_gs = 0; model_clear(); end
          else m_frame++;
        end
      end
    endcase
  endfunction

  function automatic void push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.gs = m_gs; e.lights = m_lights; e.x1 = m_x1; e.x2 = m_x2;
    e.win = m_win; e.fs = m_fs;
    sb.push_back(e);
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".state"},  int'(bus.game_state),  e.gs);
    check({e.tag, ".lights"}, int'(bus.lights),      e.lights);
    check({e.tag, ".xpos1"},  int'(bus.xpos_p1),     e.x1);
    check({e.tag, ".xpos2"},  int'(bus.xpos_p2),     e.x2);
    check({e.tag, ".winner"}, int'(bus.winner),      e.win);
    check({e.tag, ".fs"},     int'(bus.false_start), e.fs);
  endtask

  task automatic press(input logic [3:0] k, input string tag);
    @(negedge clk) bus.key_code = k;
    @(negedge clk) bus.key_code = KEY_NONE;
    model_step(int'(k), 1'b0);
    push_exp(tag);
    compare_out();
  endtask

  // One frame; a non-zero key lands in the same clock as the derived tick.
  task automatic frame(input logic [3:0] k, input string tag);
    @(negedge clk) bus.vblnk_in = 1'b1;
    @(negedge clk) bus.key_code = k;
    @(negedge clk) bus.key_code = KEY_NONE;
    @(negedge clk) bus.vblnk_in = 1'b0;
    repeat (2) @(negedge clk);
    model_step(int'(k), 1'b1);
    push_exp(tag);
    compare_out();
  endtask

  task automatic start_race();
    press(KEY_ENTER, "enter");
    for (int i = 0; i < 180; i++) frame(KEY_NONE, "cd");
  endtask

  initial begin
    bus.key_code = KEY_NONE;
    bus.vblnk_in = 1'b0;
    m_gs = 0;
    model_clear();
    repeat (3) @(negedge clk);
    push_exp("reset");
    compare_out();
    rst = 1'b1;

    // Ignored keys in MENU
    press(KEY_P1, "menu_p1");
    press(4'd9, "menu_unk");

    // Full countdown, with exact tick-to-state latency on the last light
    press(KEY_ENTER, "enter");
    for (int i = 0; i < 179; i++) frame(KEY_NONE, "cd");
    @(negedge clk) bus.vblnk_in = 1'b1;
    @(negedge clk) check("lat_pre", int'(bus.game_state), m_gs);
    model_step(0, 1'b1);
    @(negedge clk) check("lat_post", int'(bus.game_state), m_gs);
    bus.vblnk_in = 1'b0;
    repeat (2) @(negedge clk);
    push_exp("cd_last");
    compare_out();

    // Saturating throttle, then key and tick in the same clock
    for (int i = 0; i < 20; i++) press(KEY_P1, "p1_acc");
    frame(KEY_NONE, "sat_move");
    frame(KEY_P1, "key_tick");
    frame(KEY_P2, "key_tick2");
    for (int i = 0; i < 3; i++) frame(KEY_NONE, "race");
    press(KEY_ESC, "esc_race");

    // False start by P2 at lights=2, then ENTER back to MENU
    press(KEY_ENTER, "enter");
    for (int i = 0; i < 60; i++) frame(KEY_NONE, "cd");
    press(KEY_P2, "false_p2");
    frame(KEY_NONE, "fin_hold");
    press(KEY_ENTER, "fin_enter");

    // False start by P1
    press(KEY_ENTER, "enter");
    press(KEY_P1, "false_p1");
    press(KEY_ESC, "esc_fin");

    // Dead heat at the line, then automatic return after the result hold
    start_race();
    for (int i = 0; i < 12; i++) begin
      press(KEY_P1, "tie_p1");
      press(KEY_P2, "tie_p2");
    end
    for (int i = 0; i < 40 && m_gs == 2; i++) begin
      frame(KEY_NONE, "tie_run");
      press(KEY_P1, "tie_keep1");
      press(KEY_P2, "tie_keep2");
    end
    for (int i = 0; i < 300; i++) frame(KEY_NONE, "result");

    // Coasting from speed 8 down to standstill
    start_race();
    press(KEY_P1, "coast_p1");
    press(KEY_P1, "coast_p1");
    for (int i = 0; i < 34; i++) frame(KEY_NONE, "coast");

    // Asynchronous reset mid-countdown
    press(KEY_ENTER, "enter");
    for (int i = 0; i < 70; i++) frame(KEY_NONE, "cd");
    @(negedge clk) rst = 1'b0;
    #1;
    m_gs = 0;
    model_clear();
    push_exp("async_rst");
    compare_out();
    @(negedge clk) rst = 1'b1;
    press(KEY_ENTER, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
